// File: rtl/ucsbece154b_icache.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_icache
// Purpose  : Direct-mapped read-only instruction cache with multi-beat refill.
// Revision : 1.0
// ============================================================================
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadAddress_i,
    output logic [31:0] Instruction_o,
    output logic        Ready_o,
    output logic        Busy_o,
    output logic        MemReadRequest_o,
    output logic [31:0] MemReadAddress_o,
    input  logic [31:0] MemDataIn_i,
    input  logic        MemDataReady_i
);

    localparam int c_OFF = $clog2(BLOCK_WORDS);
    localparam int c_IDX = $clog2(NUM_SETS);
    localparam int c_TAG = 30 - c_OFF - c_IDX;
    localparam logic [c_OFF-1:0] c_LAST_BEAT = c_OFF'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SETS-1:0] valid_q;
    logic [c_TAG-1:0]   tag_q  [NUM_SETS];
    logic [31:0]        data_q [NUM_SETS][BLOCK_WORDS];
    logic [31:0]        blk_addr_q, blk_addr_d;
    logic [c_OFF-1:0]   beat_q, beat_d;

    logic [c_OFF-1:0]   w_off;
    logic [c_IDX-1:0]   w_idx;
    logic [c_TAG-1:0]   w_tag;
    logic [c_IDX-1:0]   w_fill_idx;
    logic [c_TAG-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_fill_we;
    logic               w_fill_last;
    logic               w_unused;

    assign w_off      = ReadAddress_i[c_OFF+1:2];
    assign w_idx      = ReadAddress_i[c_OFF+c_IDX+1:c_OFF+2];
    assign w_tag      = ReadAddress_i[31:c_OFF+c_IDX+2];
    assign w_fill_idx = blk_addr_q[c_OFF+c_IDX+1:c_OFF+2];
    assign w_fill_tag = blk_addr_q[31:c_OFF+c_IDX+2];
    assign w_unused   = &{1'b0, ReadAddress_i[1:0]};

    // Lookups only count while idle; a line being refilled is never reported.
    assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag) && (state_q == S_IDLE);

    always_comb begin
        state_d          = state_q;
        blk_addr_d       = blk_addr_q;
        beat_d           = beat_q;
        w_fill_we        = 1'b0;
        w_fill_last      = 1'b0;
        Instruction_o    = data_q[w_idx][w_off];
        Ready_o          = w_hit && !reset;
        Busy_o           = !w_hit && !reset;
        MemReadRequest_o = (state_q == S_REQ) && !reset;
        MemReadAddress_o = reset ? 32'd0 : blk_addr_q;

        case (state_q)
            S_IDLE: begin
                if (!w_hit) begin
                    blk_addr_d = {ReadAddress_i[31:c_OFF+2], {(c_OFF+2){1'b0}}};
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (MemDataReady_i && !reset) begin
                    w_fill_we = 1'b1;
                    if (beat_q == c_LAST_BEAT) begin
                        w_fill_last = 1'b1;
                        beat_d      = '0;
                        state_d     = S_IDLE;
                    end else begin
                        beat_d = beat_q + c_OFF'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            blk_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            blk_addr_q <= blk_addr_d;
            if (w_fill_last) begin
                valid_q[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            data_q[w_fill_idx][beat_q] <= MemDataIn_i;
        end
        if (w_fill_last) begin
            tag_q[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154b_icache
// Purpose  : Directed self-checking bench for the instruction cache.
// Revision : 1.0
// ============================================================================
module tb_ucsbece154b_icache;

    logic        clk;
    logic        reset;
    logic [31:0] ReadAddress_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic        Busy_o;
    logic        MemReadRequest_o;
    logic [31:0] MemReadAddress_o;
    logic [31:0] MemDataIn_i;
    logic        MemDataReady_i;

    int checks = 0;
    int errors = 0;

    ucsbece154b_icache #(
        .NUM_SETS    (8),
        .BLOCK_WORDS (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ReadAddress_i    (ReadAddress_i),
        .Instruction_o    (Instruction_o),
        .Ready_o          (Ready_o),
        .Busy_o           (Busy_o),
        .MemReadRequest_o (MemReadRequest_o),
        .MemReadAddress_o (MemReadAddress_o),
        .MemDataIn_i      (MemDataIn_i),
        .MemDataReady_i   (MemDataReady_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plays the memory side of one refill starting from the miss cycle.
    task automatic fill(input logic [31:0] base, input int lat, input int gap,
                        input int redir_cyc, input logic [31:0] redir_addr,
                        output int busy_n, output int req_n, output int ready_n,
                        output logic [31:0] req_a);
        int cyc   = 0;
        int beats = 0;
        int idle  = lat;
        busy_n  = 0;
        req_n   = 0;
        ready_n = 0;
        req_a   = 32'hFFFF_FFFF;
        while (beats < 4 && cyc < 100) begin
            MemDataReady_i = 1'b0;
            if (cyc == redir_cyc) ReadAddress_i = redir_addr;
            if (cyc >= 2) begin
                if (idle == 0) begin
                    MemDataReady_i = 1'b1;
                    MemDataIn_i    = base + beats;
                    beats++;
                    idle = gap;
                end else begin
                    idle--;
                end
            end
            #1;
            if (Busy_o) busy_n++;
            if (Ready_o) ready_n++;
            if (MemReadRequest_o) begin
                req_n++;
                req_a = MemReadAddress_o;
            end
            tick();
            cyc++;
        end
        MemDataReady_i = 1'b0;
        chk("fill_beats_delivered", beats, 4);
    endtask

    int          busy_n, req_n, ready_n;
    logic [31:0] req_a;

    initial begin
        reset          = 1'b1;
        ReadAddress_i  = 32'h0;
        MemDataIn_i    = 32'h0;
        MemDataReady_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", Ready_o, 0);
        chk("rst_busy", Busy_o, 0);
        chk("rst_req", MemReadRequest_o, 0);
        chk("rst_memaddr", MemReadAddress_o, 0);

        // Cold miss at 0x10, L=3 back-to-back beats
        reset         = 1'b0;
        ReadAddress_i = 32'h10;
        fill(32'hA0, 3, 0, -1, 32'h0, busy_n, req_n, ready_n, req_a);
        chk("cold_busy_cycles", busy_n, 9);
        chk("cold_req_pulses", req_n, 1);
        chk("cold_req_addr", req_a, 32'h10);
        chk("cold_ready_during_fill", ready_n, 0);
        #1;
        chk("cold_instr", Instruction_o, 32'hA0);
        chk("cold_ready", Ready_o, 1);
        chk("cold_busy_after", Busy_o, 0);
        tick();

        // Hits in the filled block
        ReadAddress_i = 32'h14; #1;
        chk("hit14_instr", Instruction_o, 32'hA1);
        chk("hit14_ready", Ready_o, 1);
        tick();
        ReadAddress_i = 32'h18; #1;
        chk("hit18_instr", Instruction_o, 32'hA2);
        chk("hit18_req", MemReadRequest_o, 0);
        tick();
        ReadAddress_i = 32'h1C; #1;
        chk("hit1c_instr", Instruction_o, 32'hA3);
        chk("hit1c_busy", Busy_o, 0);
        tick();
        chk("hits_no_req", MemReadRequest_o, 0);

        // Conflict eviction: 0x90 shares index 1 with 0x10
        ReadAddress_i = 32'h90;
        fill(32'hB0, 1, 0, -1, 32'h0, busy_n, req_n, ready_n, req_a);
        chk("conf90_busy_cycles", busy_n, 7);
        chk("conf90_req_addr", req_a, 32'h90);
        #1;
        chk("conf90_instr", Instruction_o, 32'hB0);
        chk("conf90_ready", Ready_o, 1);
        tick();
        ReadAddress_i = 32'h10;
        fill(32'hA0, 0, 0, -1, 32'h0, busy_n, req_n, ready_n, req_a);
        chk("refetch10_busy_cycles", busy_n, 6);
        chk("refetch10_req_pulses", req_n, 1);
        chk("refetch10_req_addr", req_a, 32'h10);
        #1;
        chk("refetch10_instr", Instruction_o, 32'hA0);
        tick();

        // Stray beats while idle must not touch anything
        MemDataReady_i = 1'b1;
        MemDataIn_i    = 32'hDEAD_BEEF;
        #1;
        chk("stray_req", MemReadRequest_o, 0);
        tick();
        tick();
        MemDataReady_i = 1'b0;
        #1;
        chk("stray_instr", Instruction_o, 32'hA0);
        chk("stray_ready", Ready_o, 1);
        tick();

        // Gapped refill into index 4
        ReadAddress_i = 32'h40;
        fill(32'hC0, 2, 2, -1, 32'h0, busy_n, req_n, ready_n, req_a);
        chk("gap_busy_cycles", busy_n, 14);
        chk("gap_ready_during_fill", ready_n, 0);
        chk("gap_req_addr", req_a, 32'h40);
        #1;
        chk("gap_w0", Instruction_o, 32'hC0);
        tick();
        ReadAddress_i = 32'h44; #1;
        chk("gap_w1", Instruction_o, 32'hC1);
        tick();
        ReadAddress_i = 32'h48; #1;
        chk("gap_w2", Instruction_o, 32'hC2);
        tick();
        ReadAddress_i = 32'h4C; #1;
        chk("gap_w3", Instruction_o, 32'hC3);
        chk("gap_w3_ready", Ready_o, 1);
        tick();

        // Redirect to 0x200 in the middle of the 0x60 refill
        ReadAddress_i = 32'h60;
        fill(32'hD0, 1, 1, 4, 32'h200, busy_n, req_n, ready_n, req_a);
        chk("redir_busy_cycles", busy_n, 10);
        chk("redir_req_pulses", req_n, 1);
        chk("redir_req_addr", req_a, 32'h60);
        fill(32'hE0, 0, 0, -1, 32'h0, busy_n, req_n, ready_n, req_a);
        chk("redir200_req_pulses", req_n, 1);
        chk("redir200_req_addr", req_a, 32'h200);
        #1;
        chk("redir200_instr", Instruction_o, 32'hE0);
        tick();
        ReadAddress_i = 32'h60; #1;
        chk("redir60_ready", Ready_o, 1);
        chk("redir60_instr", Instruction_o, 32'hD0);
        tick();
        ReadAddress_i = 32'h6C; #1;
        chk("redir6c_instr", Instruction_o, 32'hD3);
        tick();

        // Reset after two beats of a refill
        ReadAddress_i = 32'h80; #1;
        chk("rmid_miss_busy", Busy_o, 1);
        tick();
        tick();
        MemDataReady_i = 1'b1;
        MemDataIn_i    = 32'hF0;
        tick();
        MemDataIn_i    = 32'hF1;
        tick();
        MemDataReady_i = 1'b0;
        reset          = 1'b1;
        #1;
        chk("rmid_busy", Busy_o, 0);
        chk("rmid_ready", Ready_o, 0);
        chk("rmid_req", MemReadRequest_o, 0);
        chk("rmid_memaddr", MemReadAddress_o, 0);
        tick();
        chk("rmid_busy_held", Busy_o, 0);
        reset = 1'b0;
        fill(32'hF0, 0, 0, -1, 32'h0, busy_n, req_n, ready_n, req_a);
        chk("rmid_refill_req_pulses", req_n, 1);
        chk("rmid_refill_busy_cycles", busy_n, 6);
        chk("rmid_refill_req_addr", req_a, 32'h80);
        #1;
        chk("rmid_refill_instr", Instruction_o, 32'hF0);
        tick();
        ReadAddress_i = 32'h10; #1;
        chk("rmid_old_line_invalid", Ready_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_icache.md
# ucsbece154b_icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch PC and main memory, replacing the zero-latency instruction memory. Hits return the instruction combinationally in the same cycle as the PC. Misses assert a stall to the hazard unit and run a block refill over a single-request, multi-beat memory port.

## Interface
- `NUM_SETS`, default 8: number of lines; power of two, ≥2.
- `BLOCK_WORDS`, default 4: 32-bit words per line; power of two, ≥2.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `ReadAddress_i` input, 32 bits: fetch PC (PCF); bits [1:0] ignored.
- `Instruction_o` output, 32 bits: instruction at `ReadAddress_i`; valid only when `Ready_o`=1.
- `Ready_o` output, 1 bit: hit, and the FSM is in IDLE.
- `Busy_o` output, 1 bit: stall request to the hazard unit; equals ~`Ready_o`, forced 0 during reset.
- `MemReadRequest_o` output, 1 bit: one-cycle refill request pulse.
- `MemReadAddress_o` output, 32 bits: block-aligned refill address (offset bits zero).
- `MemDataIn_i` input, 32 bits: refill beat data.
- `MemDataReady_i` input, 1 bit: refill beat valid.

## Operation
- Address split:
  - Word offset = `ReadAddress_i`[OFF+1:2], where OFF = log2(`BLOCK_WORDS`).
  - Index = next log2(`NUM_SETS`) bits.
  - Tag = remaining upper bits.
- Storage per line: valid bit, tag, and `BLOCK_WORDS` data words.
- Hit condition: valid[index] && tag match && state==IDLE. `Instruction_o` = data[index][offset].
- Miss in IDLE: latch the block-aligned address; state moves to REQ on the next edge.
- FSM states:
  - IDLE: lookup only.
  - REQ: `MemReadRequest_o`=1 for exactly one cycle; `MemReadAddress_o` = latched block address; next state WAIT.
  - WAIT: each cycle with `MemDataReady_i`=1 writes `MemDataIn_i` into data[index][beat] and increments the beat counter.
    - Beats arrive in ascending word order, starting at word 0.
    - Gaps between beats are legal.
    - On the last beat (counter == `BLOCK_WORDS`-1): write the tag, set valid, clear the counter, go to IDLE.
- Valid is never set before the full line is written. A partially filled line is never a hit.
- Replacement: the refill overwrites the indexed line unconditionally. No write path; no dirty state.
- `MemDataReady_i` while in IDLE or REQ is ignored; no storage is modified.
- Changes to `ReadAddress_i` during REQ/WAIT (e.g. mispredict redirect) are ignored. The fill always completes for the latched block, and the lookup resumes in IDLE with whatever address is presented then.
- Reset:
  - All valid bits cleared; state=IDLE; beat counter=0.
  - `MemReadRequest_o`=0, `MemReadAddress_o`=0, `Ready_o`=0, `Busy_o`=0.
  - Tag and data arrays are not reset.

## Timing
- Hit: zero cycles, combinational from `ReadAddress_i` to `Instruction_o`/`Ready_o`.
- Miss timeline:
  - Cycle 0: miss detected in IDLE; `Busy_o`=1.
  - Cycle 1: REQ.
  - Cycle 2 onward: WAIT.
  - The cycle after the last beat: IDLE with a hit, `Busy_o`=0.
- Miss penalty = 2 + L + `BLOCK_WORDS`, where L is the memory cycles from request to first beat and beats are back-to-back.
- `Busy_o` stays high continuously from the miss cycle through the last-beat cycle.
- Reset asserted mid-fill: the next state is IDLE, all lines invalid, and the partial line is discarded. The memory shares `reset`, so no further beats are expected.
- Cold cache after reset: the first lookup misses.

## Test plan
- Cold miss:
  - Stimulus: reset, then `ReadAddress_i`=0x0000_0010; memory returns 0xA0..0xA3 with L=3, back-to-back.
  - Required response: `Busy_o` high for 9 cycles; `MemReadRequest_o` one pulse with address 0x0000_0010; then `Instruction_o`=0xA0 with `Ready_o`=1.
- Hits within the filled block:
  - Stimulus: step `ReadAddress_i` through 0x14, 0x18, 0x1C.
  - Required response: `Instruction_o` = 0xA1, 0xA2, 0xA3 in consecutive cycles; no memory request.
- Conflict eviction (`NUM_SETS`=8, `BLOCK_WORDS`=4):
  - Stimulus: 0x0000_0090 (same index, different tag) misses and fills 0xB0..; then 0x0000_0010 again.
  - Required response: 0x90 hits with 0xB0; 0x10 misses and refetches.
- Gapped beats plus stray data:
  - Stimulus: `MemDataReady_i` pulsed in IDLE; then a refill with idle cycles between beats.
  - Required response: the stray pulse changes nothing; the line is correct; `Ready_o`=0 until after the 4th beat.
- Redirect during fill:
  - Stimulus: `ReadAddress_i` changes to 0x0000_0200 mid-WAIT.
  - Required response: the original block completes and becomes valid; 0x200 then misses with a new request.
- Reset mid-fill:
  - Stimulus: assert `reset` after 2 beats.
  - Required response: all outputs at reset values; the next access to the same address misses.
